iota_lfsr_stage: RTL and testbench

Parametrised, pipelined iota step for Keccak-p[b, nr] permutations. Each accepted state XORs lane (0,0) with the round constant for its round index. Round constants come from an internal 8-bit LFSR (FIPS 202 Algorithm 5), advanced 7 steps per round, instead of a fixed 64-bit table. The block sits after chi in the round datapath and works for every lane width from 1 to 64 bits, with a ready/valid handshake and round tracking.

---
 rtl/iota_lfsr_stage_if.sv | 50 +++++
 rtl/iota_lfsr_stage.sv | 147 ++++++++++++++
 tb/tb_iota_lfsr_stage.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iota_lfsr_stage_if.sv
// iota_lfsr_stage_if
//   Handshake and data bundle for the iota stage.
//   master : upstream/downstream environment (drives inValid, inFirst,
//            inData, inDownReady).
//   slave  : the iota stage itself (drives outReady, outValid, outData,
//            outRound, outLast, outSeqErr).
//   L      : log2 of the lane width; state width is 25 * 2^L.
interface iota_lfsr_stage_if #(
    parameter int L = 6
);
    localparam int W = 1 << L;
    localparam int B = 25 * W;

    logic         inValid;
    logic         inFirst;
    logic [B-1:0] inData;
    logic         outReady;
    logic         outValid;
    logic         inDownReady;
    logic [B-1:0] outData;
    logic [4:0]   outRound;
    logic         outLast;
    logic         outSeqErr;

    modport master (
        output inValid,
        output inFirst,
        output inData,
        output inDownReady,
        input  outReady,
        input  outValid,
        input  outData,
        input  outRound,
        input  outLast,
        input  outSeqErr
    );

    modport slave (
        input  inValid,
        input  inFirst,
        input  inData,
        input  inDownReady,
        output outReady,
        output outValid,
        output outData,
        output outRound,
        output outLast,
        output outSeqErr
    );
endinterface

// File: rtl/iota_lfsr_stage.sv
// iota_lfsr_stage
//   Pipelined Keccak iota step. Each accepted state has lane (0,0) XORed
//   with the round constant of its round index; the constants come from the
//   8-bit Keccak LFSR, advanced 7 steps per round, rather than from a table.
//   One register stage, ready/valid on both sides, round tracking and a
//   sticky sequence-error flag.
//
//   Parameters
//     L   : log2 of lane width (0..6)
//     NR  : rounds per permutation (1..12+2*L); first round is 12+2*L-NR
//   Ports
//     inClk  : clock, rising edge
//     inRstN : asynchronous active-low reset
//     bus    : iota_lfsr_stage_if slave modport (handshake, state in/out,
//              round index, last-round flag, sequence error)
module iota_lfsr_stage #(
    parameter int L  = 6,
    parameter int NR = 12 + 2 * L
) (
    input  logic              inClk,
    input  logic              inRstN,
    iota_lfsr_stage_if.slave  bus
);

    localparam int W    = 1 << L;
    localparam int B    = 25 * W;
    localparam int NMAX = 12 + 2 * L;
    localparam int IR0  = NMAX - NR;

    localparam logic [4:0] IR0_V  = 5'(IR0);
    localparam logic [4:0] LAST_V = 5'(NMAX - 1);

    // Bit i of the register corresponds to R[i] of the FIPS 202 LFSR, so the
    // seed "10000000" (R[0] = 1) is 8'h01 here. One step shifts toward the
    // MSB and folds the carry-out back into R[0], R[4], R[5], R[6].
    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        logic [7:0] n;
        n = {r[6:0], 1'b0};
        if (r[7]) begin
            n = n ^ 8'h71;
        end
        return n;
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] r, input int steps);
        logic [7:0] s;
        s = r;
        for (int i = 0; i < steps; i++) begin
            s = lfsr_step(s);
        end
        return s;
    endfunction

    // Round constant of the round whose LFSR state is s: bit 2^j-1 takes the
    // LFSR output after j further steps, for j = 0..L.
    function automatic logic [W-1:0] round_const(input logic [7:0] s);
        logic [7:0]   r;
        logic [W-1:0] rc;
        r  = s;
        rc = '0;
        for (int j = 0; j <= L; j++) begin
            rc[(1 << j) - 1] = r[0];
            r = lfsr_step(r);
        end
        return rc;
    endfunction

    localparam logic [7:0] LFSR_IR0 = lfsr_adv(8'h01, 7 * IR0);

    logic [4:0]   cnt;
    logic [7:0]   lfsr;
    logic         busy;

    logic         out_valid;
    logic [B-1:0] out_data;
    logic [4:0]   out_round;
    logic         out_last;
    logic         seq_err;

    logic         ready;
    logic         accept;
    logic         drain;
    logic         restart;
    logic [4:0]   ir_eff;
    logic [7:0]   lfsr_use;
    logic [7:0]   lfsr_next;
    logic [W-1:0] rc;
    logic         is_last;

    // Single register stage without skid buffer: ready follows the
    // downstream ready combinationally whenever the stage is occupied.
    assign ready  = !out_valid || bus.inDownReady;
    assign accept = bus.inValid && ready;
    assign drain  = out_valid && bus.inDownReady;

    // A state arriving while idle is treated as round IR0 even without
    // inFirst; the error flag records that the sequence was broken.
    assign restart   = bus.inFirst || !busy;
    assign ir_eff    = restart ? IR0_V : cnt;
    assign lfsr_use  = (ir_eff == IR0_V) ? LFSR_IR0 : lfsr;
    assign lfsr_next = lfsr_adv(lfsr_use, 7);
    assign rc        = round_const(lfsr_use);
    assign is_last   = (ir_eff == LAST_V);

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            cnt       <= IR0_V;
            lfsr      <= LFSR_IR0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_round <= 5'd0;
            out_last  <= 1'b0;
            seq_err   <= 1'b0;
        end else if (accept) begin
            out_valid        <= 1'b1;
            out_data[B-1:W]  <= bus.inData[B-1:W];
            out_data[W-1:0]  <= bus.inData[W-1:0] ^ rc;
            out_round        <= ir_eff;
            out_last         <= is_last;
            if (is_last) begin
                cnt  <= IR0_V;
                lfsr <= LFSR_IR0;
                busy <= 1'b0;
            end else begin
                cnt  <= ir_eff + 5'd1;
                lfsr <= lfsr_next;
                busy <= 1'b1;
            end
            if (bus.inFirst) begin
                seq_err <= 1'b0;
            end else if (!busy) begin
                seq_err <= 1'b1;
            end
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.outReady  = ready;
    assign bus.outValid  = out_valid;
    assign bus.outData   = out_data;
    assign bus.outRound  = out_round;
    assign bus.outLast   = out_last;
    assign bus.outSeqErr = seq_err;

endmodule

// File: tb/tb_iota_lfsr_stage.sv
module tb_iota_lfsr_stage;

    localparam int BA = 1600;
    localparam int BB = 200;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    // reference model state for the L=6, NR=24 instance
    bit            m_valid;
    bit            m_busy;
    bit            m_err;
    bit            m_last;
    int            m_cnt;
    int            m_round;
    logic [BA-1:0] m_data;

    iota_lfsr_stage_if #(.L(6)) bus_a ();
    iota_lfsr_stage_if #(.L(3)) bus_b ();

    iota_lfsr_stage #(.L(6), .NR(24)) dut_a (
        .inClk  (clk),
        .inRstN (rst_n),
        .bus    (bus_a)
    );

    iota_lfsr_stage #(.L(3), .NR(18)) dut_b (
        .inClk  (clk),
        .inRstN (rst_n),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rc(t) written straight from the FIPS 202 algorithm on an R[0..8] array
    function automatic bit rc_bit(input int t);
        bit r [0:8];
        if (t % 255 == 0) return 1'b1;
        for (int k = 0; k < 9; k++) r[k] = 1'b0;
        r[0] = 1'b1;
        for (int i = 1; i <= t % 255; i++) begin
            for (int k = 8; k > 0; k--) r[k] = r[k-1];
            r[0] = 1'b0;
            r[0] = r[0] ^ r[8];
            r[4] = r[4] ^ r[8];
            r[5] = r[5] ^ r[8];
            r[6] = r[6] ^ r[8];
        end
        return r[0];
    endfunction

    function automatic logic [63:0] rc64(input int ir);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j <= 6; j++) v[(1 << j) - 1] = rc_bit(j + 7 * ir);
        return v;
    endfunction

    function automatic logic [BA-1:0] rand_state();
        logic [BA-1:0] s;
        for (int i = 0; i < BA / 32; i++) s[i*32 +: 32] = $urandom();
        return s;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_busy = 0; m_err = 0; m_last = 0;
        m_cnt = 0; m_round = 0; m_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_a.inValid = 0; bus_a.inFirst = 0; bus_a.inData = '0; bus_a.inDownReady = 1;
        bus_b.inValid = 0; bus_b.inFirst = 0; bus_b.inData = '0; bus_b.inDownReady = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // one clock of the L=6 instance: drive, check ready, clock, update model, check outputs
    task automatic step_a(input bit v, input bit f, input logic [BA-1:0] d, input bit dr);
        bit acc;
        int ir;
        int k;
        bus_a.inValid = v; bus_a.inFirst = f; bus_a.inData = d; bus_a.inDownReady = dr;
        #1;
        vectors++;
        if (bus_a.outReady !== (!m_valid || dr)) begin
            miscompares++;
            $display("FAIL outReady: got %b expected %b", bus_a.outReady, (!m_valid || dr));
        end
        acc = v && (!m_valid || dr);
        @(posedge clk);
        if (acc) begin
            ir = (f || !m_busy) ? 0 : m_cnt;
            if (f) m_err = 0;
            else if (!m_busy) m_err = 1;
            m_data = d;
            m_data[63:0] = m_data[63:0] ^ rc64(ir);
            m_round = ir;
            m_last = (ir == 23);
            m_busy = (ir != 23);
            m_cnt = (ir == 23) ? 0 : ir + 1;
            m_valid = 1;
        end else if (m_valid && dr) begin
            m_valid = 0;
        end
        #1;
        vectors++;
        if (bus_a.outValid !== m_valid) begin
            miscompares++;
            $display("FAIL outValid: got %b expected %b", bus_a.outValid, m_valid);
        end
        vectors++;
        if (bus_a.outData !== m_data) begin
            miscompares++;
            k = 0;
            for (int i = 24; i >= 0; i--) if (bus_a.outData[i*64 +: 64] !== m_data[i*64 +: 64]) k = i;
            $display("FAIL outData lane %0d: got %h expected %h", k, bus_a.outData[k*64 +: 64], m_data[k*64 +: 64]);
        end
        vectors++;
        if (bus_a.outRound !== 5'(m_round)) begin
            miscompares++;
            $display("FAIL outRound: got %0d expected %0d", bus_a.outRound, m_round);
        end
        vectors++;
        if (bus_a.outLast !== m_last) begin
            miscompares++;
            $display("FAIL outLast: got %b expected %b", bus_a.outLast, m_last);
        end
        vectors++;
        if (bus_a.outSeqErr !== m_err) begin
            miscompares++;
            $display("FAIL outSeqErr: got %b expected %b", bus_a.outSeqErr, m_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus_a.outValid, bus_a.outRound, bus_a.outLast, bus_a.outSeqErr} !== 8'b0 || bus_a.outData !== '0) begin
            miscompares++;
            $display("FAIL reset_a: got valid=%b round=%0d last=%b err=%b lane0=%h expected all zero",
                     bus_a.outValid, bus_a.outRound, bus_a.outLast, bus_a.outSeqErr, bus_a.outData[63:0]);
        end
        vectors++;
        if ({bus_b.outValid, bus_b.outRound, bus_b.outLast, bus_b.outSeqErr} !== 8'b0 || bus_b.outData !== '0) begin
            miscompares++;
            $display("FAIL reset_b: got valid=%b round=%0d last=%b err=%b lane0=%h expected all zero",
                     bus_b.outValid, bus_b.outRound, bus_b.outLast, bus_b.outSeqErr, bus_b.outData[7:0]);
        end
        vectors++;
        if (bus_a.outReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 1", bus_a.outReady);
        end
    endtask

    task automatic test_known_vectors();
        do_reset();
        for (int r = 0; r < 24; r++) begin
            step_a(1, r == 0, '0, 1);
            if (r == 0) begin
                vectors++;
                if (bus_a.outData[63:0] !== 64'h0000000000000001) begin
                    miscompares++;
                    $display("FAIL kv_round0: got %h expected 0000000000000001", bus_a.outData[63:0]);
                end
            end
            if (r == 1) begin
                vectors++;
                if (bus_a.outData[63:0] !== 64'h0000000000008082) begin
                    miscompares++;
                    $display("FAIL kv_round1: got %h expected 0000000000008082", bus_a.outData[63:0]);
                end
            end
            if (r == 23) begin
                vectors++;
                if (bus_a.outData[63:0] !== 64'h8000000080008008 || bus_a.outLast !== 1'b1) begin
                    miscompares++;
                    $display("FAIL kv_round23: got %h last=%b expected 8000000080008008 last=1",
                             bus_a.outData[63:0], bus_a.outLast);
                end
            end else begin
                vectors++;
                if (bus_a.outLast !== 1'b0) begin
                    miscompares++;
                    $display("FAIL kv_last_early: round %0d got outLast=%b expected 0", r, bus_a.outLast);
                end
            end
        end
        step_a(0, 0, '0, 1);
    endtask

    task automatic test_l3();
        logic [7:0] exp_lane [3];
        exp_lane[0] = 8'h01; exp_lane[1] = 8'h82; exp_lane[2] = 8'h8A;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            bus_b.inValid = 1; bus_b.inFirst = (r == 0); bus_b.inData = '0; bus_b.inDownReady = 1;
            @(posedge clk);
            #1;
            vectors++;
            if (bus_b.outData[7:0] !== exp_lane[r] || bus_b.outRound !== 5'(r) || bus_b.outValid !== 1'b1) begin
                miscompares++;
                $display("FAIL l3_lane: round %0d got lane=%h round=%0d valid=%b expected lane=%h",
                         r, bus_b.outData[7:0], bus_b.outRound, bus_b.outValid, exp_lane[r]);
            end
            vectors++;
            if (bus_b.outData[BB-1:8] !== '0 || bus_b.outLast !== 1'b0 || bus_b.outSeqErr !== 1'b0) begin
                miscompares++;
                $display("FAIL l3_upper: round %0d got upper nonzero=%b last=%b err=%b expected 0 0 0",
                         r, |bus_b.outData[BB-1:8], bus_b.outLast, bus_b.outSeqErr);
            end
        end
        bus_b.inValid = 0; bus_b.inFirst = 0;
    endtask

    task automatic test_backpressure();
        logic [BA-1:0] held_data;
        logic [4:0]    held_round;
        do_reset();
        for (int r = 0; r <= 4; r++) step_a(1, r == 0, rand_state(), 1);
        held_data = bus_a.outData;
        held_round = bus_a.outRound;
        for (int c = 0; c < 5; c++) begin
            step_a(1, 0, rand_state(), 0);
            vectors++;
            if (bus_a.outData !== held_data || bus_a.outRound !== held_round || bus_a.outReady !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d got round=%0d ready=%b data_same=%b expected round=%0d ready=0 data_same=1",
                         c, bus_a.outRound, bus_a.outReady, bus_a.outData === held_data, held_round);
            end
        end
        for (int r = 5; r < 24; r++) begin
            step_a(1, 0, rand_state(), 1);
            vectors++;
            if (bus_a.outRound !== 5'(r)) begin
                miscompares++;
                $display("FAIL bp_resume: got round %0d expected %0d", bus_a.outRound, r);
            end
        end
        step_a(0, 0, '0, 1);
    endtask

    task automatic test_seq_err();
        do_reset();
        step_a(1, 0, rand_state(), 1);
        vectors++;
        if (bus_a.outSeqErr !== 1'b1 || bus_a.outRound !== 5'd0) begin
            miscompares++;
            $display("FAIL seq_err_set: got err=%b round=%0d expected err=1 round=0", bus_a.outSeqErr, bus_a.outRound);
        end
        step_a(1, 0, rand_state(), 1);
        step_a(1, 1, rand_state(), 1);
        vectors++;
        if (bus_a.outSeqErr !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_err_clear: got %b expected 0", bus_a.outSeqErr);
        end
    endtask

    task automatic test_restart();
        do_reset();
        for (int r = 0; r < 10; r++) step_a(1, r == 0, '0, 1);
        step_a(1, 1, '0, 1);
        vectors++;
        if (bus_a.outRound !== 5'd0 || bus_a.outData[63:0] !== 64'h1 || bus_a.outSeqErr !== 1'b0) begin
            miscompares++;
            $display("FAIL restart: got round=%0d lane=%h err=%b expected round=0 lane=1 err=0",
                     bus_a.outRound, bus_a.outData[63:0], bus_a.outSeqErr);
        end
        step_a(1, 0, '0, 1);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step_a($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rand_state(),
                   $urandom_range(0, 3) != 0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step_a(1, 0, rand_state(), 1);
        for (int r = 0; r < 6; r++) step_a(1, 0, rand_state(), 1);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus_a.outValid, bus_a.outRound, bus_a.outLast, bus_a.outSeqErr} !== 8'b0 || bus_a.outData !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%b round=%0d last=%b err=%b lane0=%h expected all zero",
                     bus_a.outValid, bus_a.outRound, bus_a.outLast, bus_a.outSeqErr, bus_a.outData[63:0]);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step_a(1, 0, rand_state(), 1);
        step_a(1, 0, rand_state(), 1);
        step_a(1, 1, rand_state(), 1);
        step_a(1, 0, rand_state(), 1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_known_vectors();
        test_l3();
        test_backpressure();
        test_seq_err();
        test_restart();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
